// File: rtl/credit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// credit_pkg: shared constants, FSM encoding and helpers for credit_sched
// Rev 1.0
// ----------------------------------------------------------------------------
package credit_pkg;

  localparam logic [1:0] MODE_ADD   = 2'd0;
  localparam logic [1:0] MODE_SPEND = 2'd1;
  localparam logic [1:0] MODE_ALLOC = 2'd2;
  localparam logic [1:0] MODE_LIST  = 2'd3;

  localparam int LIST_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_LIST     = 3'd2,
    ST_HR_ALLOC = 3'd3,
    ST_HR_TICK  = 3'd4
  } state_t;

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    onehot_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (oh[k]) onehot_idx = 2'(k);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter4: combinational 4-way round-robin grant starting at pointer
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter4 (
  input  logic [3:0] request,
  input  logic [1:0] pointer,
  output logic [3:0] grant
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant = 4'd0;
    found = 1'b0;
    idx   = pointer;
    for (int k = 0; k < 4; k++) begin
      idx = pointer + 2'(k);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/credit_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// credit_sched: round-robin command scheduler and hourly sequencer for the ledger
// Rev 1.0
// ----------------------------------------------------------------------------
module credit_sched
  import credit_pkg::*;
#(
  parameter int         HOUR_CYCLES   = 100,
  parameter logic [2:0] HOURLY_CREDIT = 3'd3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  reqValid,
  input  logic [7:0]  reqMode,
  input  logic [11:0] reqID,
  input  logic [11:0] reqCredit,
  output logic [3:0]  reqReady,
  output logic [1:0]  mode,
  output logic [2:0]  studentID,
  output logic [2:0]  credit,
  output logic        incTime,
  input  logic [2:0]  idOutput,
  input  logic        endOfListWar,
  output logic        rspValid,
  output logic [1:0]  rspPort,
  output logic [2:0]  rspID,
  output logic        rspLast
);

  localparam int TW = $clog2(HOUR_CYCLES);

  state_t        state, state_nx;
  logic [1:0]    rr_ptr;
  logic [TW-1:0] timer;
  logic          hour_pending;
  logic          hour_clr;
  logic          timer_wrap;

  logic [1:0]    lat_port;
  logic [2:0]    lat_id;
  logic [2:0]    lat_cred;
  logic [3:0]    list_cnt, list_cnt_d;

  logic [1:0]    mode_d;
  logic [2:0]    id_d, cred_d, rid_d;
  logic          inc_d, rv_d, rl_d;
  logic [1:0]    rp_d;

  logic [3:0]    arb_req, grant;
  logic [1:0]    gi;
  logic [1:0]    port_mode [4];
  logic [2:0]    port_id   [4];
  logic [2:0]    port_cred [4];

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign port_mode[i] = reqMode[2*i +: 2];
    assign port_id[i]   = reqID[3*i +: 3];
    assign port_cred[i] = reqCredit[3*i +: 3];
  end

  // Requesters only compete in IDLE with no hour waiting; the hour has priority.
  assign arb_req = reqValid & {4{(state == ST_IDLE) && !hour_pending}};

  rr_arbiter4 u_arb (
    .request (arb_req),
    .pointer (rr_ptr),
    .grant   (grant)
  );

  assign reqReady   = grant;
  assign gi         = onehot_idx(grant);
  assign timer_wrap = (timer == TW'(HOUR_CYCLES - 1));

  always_comb begin
    state_nx   = state;
    list_cnt_d = list_cnt;
    hour_clr   = 1'b0;
    mode_d     = MODE_ADD;
    id_d       = 3'd0;
    cred_d     = 3'd0;
    inc_d      = 1'b0;
    rv_d       = 1'b0;
    rp_d       = 2'd0;
    rid_d      = 3'd0;
    rl_d       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hour_pending) begin
          state_nx = ST_HR_ALLOC;
          mode_d   = MODE_ALLOC;
          cred_d   = HOURLY_CREDIT;
        end else if (|grant) begin
          mode_d     = port_mode[gi];
          id_d       = port_id[gi];
          cred_d     = port_cred[gi];
          list_cnt_d = 4'd0;
          state_nx   = (port_mode[gi] == MODE_LIST) ? ST_LIST : ST_CMD;
        end
      end
      ST_CMD: begin
        rv_d     = 1'b1;
        rl_d     = 1'b1;
        rp_d     = lat_port;
        state_nx = ST_IDLE;
      end
      ST_LIST: begin
        rp_d = lat_port;
        if (list_cnt == 4'd0) begin
          // Ledger list outputs are not valid until the second scan cycle.
          list_cnt_d = 4'd1;
          mode_d     = MODE_LIST;
          id_d       = lat_id;
          cred_d     = lat_cred;
        end else begin
          rv_d = 1'b1;
          if (endOfListWar || (list_cnt == 4'(LIST_MAX + 1))) begin
            rl_d     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            rid_d      = idOutput;
            list_cnt_d = list_cnt + 4'd1;
            mode_d     = MODE_LIST;
            id_d       = lat_id;
            cred_d     = lat_cred;
          end
        end
      end
      ST_HR_ALLOC: begin
        inc_d    = 1'b1;
        state_nx = ST_HR_TICK;
      end
      ST_HR_TICK: begin
        hour_clr = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      rr_ptr       <= 2'd0;
      timer        <= '0;
      hour_pending <= 1'b0;
      lat_port     <= 2'd0;
      lat_id       <= 3'd0;
      lat_cred     <= 3'd0;
      list_cnt     <= 4'd0;
      mode         <= 2'd0;
      studentID    <= 3'd0;
      credit       <= 3'd0;
      incTime      <= 1'b0;
      rspValid     <= 1'b0;
      rspPort      <= 2'd0;
      rspID        <= 3'd0;
      rspLast      <= 1'b0;
    end else begin
      state     <= state_nx;
      list_cnt  <= list_cnt_d;
      mode      <= mode_d;
      studentID <= id_d;
      credit    <= cred_d;
      incTime   <= inc_d;
      rspValid  <= rv_d;
      rspPort   <= rp_d;
      rspID     <= rid_d;
      rspLast   <= rl_d;
      timer     <= timer_wrap ? '0 : timer + TW'(1);
      // A wrap landing on the clearing cycle still sees pending set, so it is dropped.
      if (hour_clr)        hour_pending <= 1'b0;
      else if (timer_wrap) hour_pending <= 1'b1;
      if (|grant) begin
        lat_port <= gi;
        lat_id   <= port_id[gi];
        lat_cred <= port_cred[gi];
        rr_ptr   <= gi + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_credit_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_credit_sched: directed scoreboard bench for credit_sched with a ledger model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_credit_sched;

  logic        CLK;
  logic        RST;
  logic [3:0]  reqValid;
  logic [7:0]  reqMode;
  logic [11:0] reqID;
  logic [11:0] reqCredit;
  logic [3:0]  reqReady;
  logic [1:0]  mode;
  logic [2:0]  studentID;
  logic [2:0]  credit;
  logic        incTime;
  logic [2:0]  idOutput;
  logic        endOfListWar;
  logic        rspValid;
  logic [1:0]  rspPort;
  logic [2:0]  rspID;
  logic        rspLast;

  credit_sched #(
    .HOUR_CYCLES   (10),
    .HOURLY_CREDIT (3'd3)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .reqValid     (reqValid),
    .reqMode      (reqMode),
    .reqID        (reqID),
    .reqCredit    (reqCredit),
    .reqReady     (reqReady),
    .mode         (mode),
    .studentID    (studentID),
    .credit       (credit),
    .incTime      (incTime),
    .idOutput     (idOutput),
    .endOfListWar (endOfListWar),
    .rspValid     (rspValid),
    .rspPort      (rspPort),
    .rspID        (rspID),
    .rspLast      (rspLast)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int port;
    int id;
    int last;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t got_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   rel0   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Ledger model: students 2 and 5 sit below a threshold of 4.
  logic [2:0] cred_tab [8];
  int         scan = 1;
  logic       nxt_found;
  logic [2:0] nxt_id;

  initial begin
    cred_tab[0] = 3'd7; cred_tab[1] = 3'd7; cred_tab[2] = 3'd1; cred_tab[3] = 3'd5;
    cred_tab[4] = 3'd6; cred_tab[5] = 3'd3; cred_tab[6] = 3'd7; cred_tab[7] = 3'd7;
  end

  always_comb begin
    nxt_found = 1'b0;
    nxt_id    = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (!nxt_found && k >= scan && cred_tab[k] < credit) begin
        nxt_found = 1'b1;
        nxt_id    = 3'(k);
      end
    end
  end

  always @(posedge CLK) begin
    if (mode == 2'd3) begin
      if (nxt_found) begin
        idOutput     <= nxt_id;
        endOfListWar <= 1'b0;
        scan         <= int'(nxt_id) + 1;
      end else begin
        idOutput     <= 3'd0;
        endOfListWar <= 1'b1;
        scan         <= 8;
      end
    end else begin
      idOutput     <= 3'd0;
      endOfListWar <= 1'b0;
      scan         <= 1;
    end
  end

  always @(negedge CLK) begin
    if (rspValid) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected cyc=%0d actual port=%0d id=%0d last=%0d required=none",
                 cyc, rspPort, rspID, rspLast);
      end else begin
        got_e = q.pop_front();
        if (int'(rspPort) != got_e.port || int'(rspID) != got_e.id ||
            int'(rspLast) != got_e.last || cyc != got_e.cyc) begin
          fails++;
          $display("FAIL rsp_match actual port=%0d id=%0d last=%0d cyc=%0d required port=%0d id=%0d last=%0d cyc=%0d",
                   rspPort, rspID, rspLast, cyc, got_e.port, got_e.id, got_e.last, got_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int p, input int id, input int last, input int c);
    exp_t e;
    e.port = p; e.id = id; e.last = last; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic issue(input int p, input int m, input int id, input int cr);
    reqMode[2*p +: 2]   = 2'(m);
    reqID[3*p +: 3]     = 3'(id);
    reqCredit[3*p +: 3] = 3'(cr);
    reqValid[p]         = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge of the cycle after the grant.
  task automatic wait_grant(input int p, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      if (reqReady != 4'd0) begin
        chk("grant_onehot", int'(reqReady), 1 << p);
        if (reqReady[p]) begin
          got = 1'b1;
          t   = cyc;
        end
      end
      if (!got) @(negedge CLK);
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL grant_timeout port=%0d actual=none required=grant", p);
    end else begin
      @(posedge CLK);
      #1 reqValid[p] = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST      = 1'b1;
    reqValid = 4'd0;
    repeat (2) @(negedge CLK);
    RST  = 1'b0;
    rel0 = cyc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_sid"}, int'(studentID), 0);
    chk({tag, "_credit"}, int'(credit), 0);
    chk({tag, "_inctime"}, int'(incTime), 0);
    chk({tag, "_rspvalid"}, int'(rspValid), 0);
    chk({tag, "_rsplast"}, int'(rspLast), 0);
  endtask

  int vec_p  [4] = '{2, 3, 1, 0};
  int vec_m  [4] = '{0, 1, 2, 0};
  int vec_id [4] = '{5, 7, 4, 1};
  int vec_cr [4] = '{0, 6, 5, 2};

  initial begin
    int t, t0, t1, t2, r;
    int em, ec, ei;
    RST = 1'b1; reqValid = 4'd0; reqMode = 8'd0; reqID = 12'd0; reqCredit = 12'd0;

    // Reset state
    do_reset();
    chk_zero("reset");
    chk("reset_rspport", int'(rspPort), 0);
    chk("reset_rspid", int'(rspID), 0);

    // Single commands, including forwarded mode 2
    for (int v = 0; v < 4; v++) begin
      issue(vec_p[v], vec_m[v], vec_id[v], vec_cr[v]);
      wait_grant(vec_p[v], t);
      if (v == 0) chk("first_grant_cycle", t - rel0, 0);
      chk("cmd_mode", int'(mode), vec_m[v]);
      chk("cmd_sid", int'(studentID), vec_id[v]);
      chk("cmd_credit", int'(credit), vec_cr[v]);
      chk("cmd_inctime", int'(incTime), 0);
      push(vec_p[v], 0, 1, t + 2);
      @(negedge CLK);
      chk("cmd_after_mode", int'(mode), 0);
      chk("cmd_after_sid", int'(studentID), 0);
    end

    // Contention and round-robin fairness
    repeat (2) @(negedge CLK);
    do_reset();
    issue(0, 1, 3, 2);
    issue(1, 0, 6, 0);
    wait_grant(0, t0);
    chk("cont_t0", t0 - rel0, 0);
    push(0, 0, 1, t0 + 2);
    issue(0, 2, 2, 1);
    wait_grant(1, t1);
    chk("cont_t1", t1 - t0, 2);
    push(1, 0, 1, t1 + 2);
    wait_grant(0, t2);
    chk("cont_t2", t2 - t1, 2);
    push(0, 0, 1, t2 + 2);

    // List scan
    repeat (3) @(negedge CLK);
    do_reset();
    issue(3, 3, 0, 4);
    wait_grant(3, t);
    chk("list_mode", int'(mode), 3);
    chk("list_credit", int'(credit), 4);
    push(3, 2, 0, t + 3);
    push(3, 5, 0, t + 4);
    push(3, 0, 1, t + 5);
    repeat (5) @(negedge CLK);

    // Hourly sequence with no requests
    do_reset();
    for (r = 0; r < 24; r++) begin
      em = (r == 11 || r == 21) ? 2 : 0;
      ec = (r == 11 || r == 21) ? 3 : 0;
      ei = (r == 12 || r == 22) ? 1 : 0;
      chk($sformatf("hour_mode_r%0d", r), int'(mode), em);
      chk($sformatf("hour_credit_r%0d", r), int'(credit), ec);
      chk($sformatf("hour_inc_r%0d", r), int'(incTime), ei);
      @(negedge CLK);
    end

    // Hour wrap during a list scan
    do_reset();
    repeat (6) @(negedge CLK);
    issue(3, 3, 0, 4);
    wait_grant(3, t);
    chk("hl_grant_cycle", t - rel0, 6);
    push(3, 2, 0, t + 3);
    push(3, 5, 0, t + 4);
    push(3, 0, 1, t + 5);
    for (r = 7; r <= 13; r++) begin
      em = (r <= 10) ? 3 : (r == 12) ? 2 : 0;
      ec = (r <= 10) ? 4 : (r == 12) ? 3 : 0;
      ei = (r == 13) ? 1 : 0;
      chk($sformatf("hl_mode_r%0d", r), int'(mode), em);
      chk($sformatf("hl_credit_r%0d", r), int'(credit), ec);
      chk($sformatf("hl_inc_r%0d", r), int'(incTime), ei);
      @(negedge CLK);
    end

    // Reset in the third list cycle
    do_reset();
    issue(1, 3, 0, 4);
    wait_grant(1, t);
    push(1, 2, 0, t + 3);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("midrst");
    RST  = 1'b0;
    rel0 = cyc;
    issue(2, 0, 4, 0);
    issue(0, 0, 1, 0);
    wait_grant(0, t0);
    push(0, 0, 1, t0 + 2);
    wait_grant(2, t1);
    push(2, 0, 1, t1 + 2);
    repeat (5) @(negedge CLK);
    chk("rsp_queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
